tl_burst_rr_arbiter: RTL and testbench
======================================

Name: tl_burst_rr_arbiter

Overview:
- Round-robin arbiter that shares one ready/valid channel (the bus-side port) among NREQ requesters.
- Once a burst starts, the grant is locked until the burst's final beat, so beats from different requesters never interleave.
- Enforces the channel invariant that at most one requester sees ready in any cycle and that no grant is held while in reset.
- Sits between the master-side request muxes and the shared downstream channel, ahead of that channel's protocol monitor.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DATA_W, 32, payload width per beat.
- BEAT_W, 3, width of burst length field; burst carries (len+1) beats, max 2^BEAT_W.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  NREQ  per-requester beat valid.
- in_ready  out  NREQ  per-requester beat accept; at most one bit set.
- in_data  in  NREQ*DATA_W  per-requester payload, requester i at [i*DATA_W +: DATA_W].
- in_len  in  NREQ*BEAT_W  beats-minus-one; sampled only on first beat of a burst.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  muxed payload of granted requester.
- out_sel  out  clog2(NREQ)  index of granted requester.
- out_first  out  1  current beat is first of burst.
- out_last  out  1  current beat is last of burst.

Behaviour:
- Reset, asynchronous on reset_n low:
  - state=IDLE, ptr=NREQ-1 (requester 0 highest priority first), beat_cnt=0, lock_idx=0.
  - All outputs 0 while reset_n low: in_ready=0, out_valid=0, out_sel=0, out_first=0, out_last=0, out_data=0.
- Handshake: a beat transfers when out_valid & out_ready. out_valid is combinational from the granted in_valid. in_ready[g]=out_ready only for the granted g; all other bits are 0.
- IDLE:
  - Combinational pick = first index with in_valid set, scanning ptr+1, ptr+2, ... modulo NREQ.
  - If no in_valid bit is set: out_valid=0.
  - Otherwise: out_sel=pick, out_first=1, out_last=(in_len[pick]==0).
  - On handshake with len==0: stay IDLE, ptr<=pick.
  - On handshake with len>0: go to LOCKED, lock_idx<=pick, beat_cnt<=len.
  - No handshake: no state change. The pick may change next cycle; the winner is not sticky before the first beat.
- LOCKED:
  - out_sel=lock_idx, out_first=0, out_last=(beat_cnt==1).
  - Other requesters' valids are ignored.
  - On handshake: beat_cnt decrements. At beat_cnt==1 go to IDLE with ptr<=lock_idx, beat_cnt<=0.
  - Requester dropping in_valid mid-burst: out_valid=0, lock is held, no timeout.
- Zero-latency datapath: no registers on data/valid/ready. Arbitration adds 0 cycles. A single requester can sustain 1 beat/cycle, including back-to-back single-beat bursts.
- Fairness: after a burst completes, the completing requester has lowest priority. No requester is starved beyond NREQ-1 intervening bursts.
- Simultaneous events: the last beat of a LOCKED burst and a new request in the same cycle give IDLE next cycle, and that new request can be granted in the next cycle.
- Reset asserted mid-burst: burst is abandoned, state returns to IDLE with ptr=NREQ-1. No partial-burst memory is kept.
- Wrap-around: ptr modulo NREQ. A full burst of len=2^BEAT_W-1 counts correctly in BEAT_W bits.
- Simulation-only checks (ifndef SYNTHESIS), each reported then fatal:
  - popcount(in_ready)>1.
  - Any in_ready high while reset_n low.

Decomposition:
- Shared package tl_arb_pkg: state enum (IDLE, LOCKED), function clog2, localparam SEL_W.
- One sub-module rr_pick: parameterised NREQ; inputs req vector and ptr; outputs pick index and any_req. Pure combinational, double-width mask scan.

Test Plan:
- Reset: reset_n=0 with all in_valid=1 -> in_ready=0, out_valid=0. Release reset, all requesters issue len=0 beats with out_ready=1 -> grants go 0,1,0,1 in consecutive cycles.
- Burst lock, NREQ=2: req0 len=3 and req1 len=0 both valid -> 4 beats from req0 with out_first only on beat 1 and out_last on beat 4; req1 is granted in cycle 5.
- Backpressure: req0 len=1, out_ready low for 3 cycles mid-burst -> out_sel stays 0, beat_cnt holds, in_ready[0]=0, no beat loss, out_data stable.
- Requester gap: req1 drops in_valid for 2 cycles mid-burst while req0 is valid -> out_valid=0, req0 is not granted until req1's burst completes.
- Reset mid-burst: reset_n pulsed low during beat 2 of an 8-beat burst from req1 -> after release, state is IDLE and req0 wins when both are valid.
- Random stress, NREQ=4, 10k cycles, random valid/ready/len -> popcount(in_ready)<=1 every cycle, no interleaving within a burst, max wait <=3 bursts.

Source files
------------

// File: rtl/tl_arb_pkg.sv
// Types and elaboration helpers shared by the burst round-robin arbiter
// and its priority picker.
package tl_arb_pkg;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  localparam int unsigned MAX_NREQ = 8;

  // Bits needed to index n items; a single item still needs no bits.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  localparam int unsigned SEL_W = clog2(MAX_NREQ);

endpackage

// File: rtl/tl_burst_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr,
// wrapping modulo NREQ.
module rr_pick
  import tl_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick,
  output logic             any_req
);

  logic [2*NREQ-1:0] dbl;

  always_comb begin
    dbl     = {req, req};
    pick    = '0;
    any_req = 1'b0;
    // The window (ptr, ptr+NREQ] of the doubled vector is the rotated scan order.
    for (int unsigned j = 0; j < 2 * NREQ; j++) begin
      if (!any_req && dbl[j] && (j > 32'(ptr)) && (j <= 32'(ptr) + NREQ)) begin
        any_req = 1'b1;
        pick    = IDX_W'(j % NREQ);
      end
    end
  end

endmodule

// File: rtl/tl_burst_rr_arbiter.sv
// Round-robin arbiter sharing one ready/valid channel among NREQ requesters,
// holding the grant for the full length of each burst.
module tl_burst_rr_arbiter
  import tl_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BEAT_W = 3
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          in_valid,
  output logic [NREQ-1:0]          in_ready,
  input  logic [NREQ*DATA_W-1:0]   in_data,
  input  logic [NREQ*BEAT_W-1:0]   in_len,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [clog2(NREQ)-1:0]   out_sel,
  output logic                     out_first,
  output logic                     out_last
);

  localparam int unsigned IDX_W = clog2(NREQ);

  arb_state_t        state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  lock_idx;
  logic [BEAT_W-1:0] beat_cnt;

  logic [IDX_W-1:0]  pick;
  logic              any_req;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_active;
  logic              grant_valid;
  logic [BEAT_W-1:0] pick_len;
  logic              handshake;

  rr_pick #(
    .NREQ (NREQ),
    .IDX_W(IDX_W)
  ) u_pick (
    .req    (in_valid),
    .ptr    (ptr),
    .pick   (pick),
    .any_req(any_req)
  );

  always_comb begin
    pick_len = in_len[int'(pick)*BEAT_W +: BEAT_W];

    if (state == LOCKED) begin
      grant_idx    = lock_idx;
      grant_active = 1'b1;
      grant_valid  = in_valid[lock_idx];
    end else begin
      grant_idx    = pick;
      grant_active = any_req;
      grant_valid  = any_req;
    end

    handshake = reset_n && grant_valid && out_ready;

    in_ready  = '0;
    out_valid = 1'b0;
    out_sel   = '0;
    out_first = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;

    // Every output is forced low while reset is held, independent of state.
    if (reset_n) begin
      out_valid = grant_valid;
      out_sel   = grant_idx;
      out_data  = in_data[int'(grant_idx)*DATA_W +: DATA_W];
      if (grant_active) in_ready[grant_idx] = out_ready;
      if (state == LOCKED) begin
        out_last = (beat_cnt == BEAT_W'(1));
      end else if (any_req) begin
        out_first = 1'b1;
        out_last  = (pick_len == '0);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= IDX_W'(NREQ - 1);
      beat_cnt <= '0;
      lock_idx <= '0;
    end else if (handshake) begin
      case (state)
        IDLE: begin
          if (pick_len == '0) begin
            ptr <= pick;
          end else begin
            state    <= LOCKED;
            lock_idx <= pick;
            beat_cnt <= pick_len;
          end
        end
        LOCKED: begin
          // beat_cnt counts beats still owed after the current one plus one.
          if (beat_cnt == BEAT_W'(1)) begin
            state    <= IDLE;
            ptr      <= lock_idx;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt - BEAT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if ((NREQ < 2) || (IDX_W > SEL_W))
      $fatal(1, "FAIL arb_param: NREQ=%0d outside supported range", NREQ);
    if ($countones(in_ready) > 1)
      $fatal(1, "FAIL arb_ready_onehot: in_ready=%b", in_ready);
    if (!reset_n && (in_ready != '0))
      $fatal(1, "FAIL arb_ready_in_reset: in_ready=%b", in_ready);
  end
`endif

endmodule

// File: tb/tb_tl_burst_rr_arbiter.sv
// Scoreboard bench for tl_burst_rr_arbiter: directed scenarios on a
// 2-requester instance and a random stress run on a 4-requester instance.
module tb_tl_burst_rr_arbiter;

  localparam int DW = 32;
  localparam int BW = 3;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]      v2, r2;
  logic [2*DW-1:0] d2;
  logic [2*BW-1:0] l2;
  logic            ov2, ordy2, of2, ol2;
  logic [DW-1:0]   od2;
  logic [0:0]      os2;

  logic [3:0]      v4, r4;
  logic [4*DW-1:0] d4;
  logic [4*BW-1:0] l4;
  logic            ov4, ordy4, of4, ol4;
  logic [DW-1:0]   od4;
  logic [1:0]      os4;

  tl_burst_rr_arbiter #(.NREQ(2), .DATA_W(DW), .BEAT_W(BW)) u_dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(v2), .in_ready(r2),
    .in_data(d2), .in_len(l2), .out_valid(ov2), .out_ready(ordy2),
    .out_data(od2), .out_sel(os2), .out_first(of2), .out_last(ol2)
  );

  tl_burst_rr_arbiter #(.NREQ(4), .DATA_W(DW), .BEAT_W(BW)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(v4), .in_ready(r4),
    .in_data(d4), .in_len(l4), .out_valid(ov4), .out_ready(ordy4),
    .out_data(od4), .out_sel(os4), .out_first(of4), .out_last(ol4)
  );

  typedef struct {
    int          sel;
    logic [DW-1:0] data;
    bit          first;
    bit          last;
  } exp_t;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t sb[$];

  // Requester-side model for the 2-port instance.
  int blen[2][64];
  int bhead[2];
  int bcnt[2];
  int bbeat[2];
  bit gap[2];

  function automatic logic [DW-1:0] mkdata(input int req, input int burst, input int beat);
    return {8'hA0 + 8'(req), 8'(burst), 8'(beat), 8'h5C};
  endfunction

  task automatic drive2();
    for (int i = 0; i < 2; i++) begin
      if (bhead[i] < bcnt[i] && !gap[i]) begin
        v2[i] = 1'b1;
        d2[i*DW +: DW] = mkdata(i, bhead[i], bbeat[i]);
        l2[i*BW +: BW] = BW'(blen[i][bhead[i]]);
      end else begin
        v2[i] = 1'b0;
        d2[i*DW +: DW] = 32'hDEAD0000 + 32'(i);
        l2[i*BW +: BW] = '0;
      end
    end
  endtask

  // Called at the falling edge: requesters advance on their own valid&ready.
  task automatic adv2();
    for (int i = 0; i < 2; i++) begin
      if (v2[i] && r2[i]) begin
        if (bbeat[i] == blen[i][bhead[i]]) begin
          bhead[i]++;
          bbeat[i] = 0;
        end else begin
          bbeat[i]++;
        end
      end
    end
    @(posedge clock);
    #1;
    drive2();
  endtask

  task automatic add_burst(input int req, input int len, output int id);
    id = bcnt[req];
    blen[req][id] = len;
    bcnt[req]++;
  endtask

  task automatic expect_beats(input int req, input int id, input int len,
                              input int from, input int to);
    for (int k = from; k <= to; k++)
      sb.push_back('{req, mkdata(req, id, k), k == 0, k == len});
  endtask

  task automatic test_reset();
    int id0, id1, cyc;
    exp_t e;
    for (int n = 0; n < 3; n++) begin
      add_burst(0, 0, id0);
      add_burst(1, 0, id1);
      expect_beats(0, id0, 0, 0, 0);
      expect_beats(1, id1, 0, 0, 0);
    end
    ordy2 = 1'b1;
    drive2();
    @(negedge clock);
    n_checks++; if (v2 !== 2'b11) $display("FAIL rst_stim: got in_valid=%b want 11", v2); else n_pass++;
    n_checks++; if (r2 !== 2'b00) $display("FAIL rst_in_ready: got %b want 00", r2); else n_pass++;
    n_checks++; if (ov2 !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", ov2); else n_pass++;
    n_checks++; if (os2 !== 1'b0) $display("FAIL rst_out_sel: got %0d want 0", os2); else n_pass++;
    n_checks++; if ({of2, ol2} !== 2'b00) $display("FAIL rst_first_last: got %b want 00", {of2, ol2}); else n_pass++;
    n_checks++; if (od2 !== '0) $display("FAIL rst_out_data: got %h want 0", od2); else n_pass++;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (ov2 && ordy2) begin
        e = sb.pop_front();
        n_checks++;
        if (os2 !== 1'(e.sel) || od2 !== e.data || of2 !== e.first || ol2 !== e.last)
          $display("FAIL rst_rr_beat: got sel=%0d data=%h f=%b l=%b want sel=%0d data=%h f=%b l=%b",
                   os2, od2, of2, ol2, e.sel, e.data, e.first, e.last);
        else n_pass++;
      end
      adv2();
    end
    n_checks++;
    if (sb.size() != 0 || cyc != 6) $display("FAIL rst_rr_cycles: got %0d cycles (%0d left) want 6", cyc, sb.size());
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_burst_lock();
    int id0, id1, cyc;
    exp_t e;
    add_burst(0, 3, id0);
    add_burst(1, 0, id1);
    expect_beats(0, id0, 3, 0, 3);
    expect_beats(1, id1, 0, 0, 0);
    drive2();
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (ov2 && ordy2) begin
        e = sb.pop_front();
        n_checks++;
        if (os2 !== 1'(e.sel) || od2 !== e.data || of2 !== e.first || ol2 !== e.last)
          $display("FAIL lock_beat: got sel=%0d data=%h f=%b l=%b want sel=%0d data=%h f=%b l=%b",
                   os2, od2, of2, ol2, e.sel, e.data, e.first, e.last);
        else n_pass++;
      end
      adv2();
    end
    n_checks++;
    if (sb.size() != 0 || cyc != 5) $display("FAIL lock_cycles: got %0d cycles (%0d left) want 5", cyc, sb.size());
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_backpressure();
    int id0, cyc;
    exp_t e;
    bit pat[5] = '{1, 0, 0, 0, 1};
    add_burst(0, 1, id0);
    expect_beats(0, id0, 1, 0, 1);
    drive2();
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      ordy2 = (cyc < 5) ? pat[cyc] : 1'b1;
      @(negedge clock);
      if (cyc >= 1 && cyc <= 3) begin
        n_checks++;
        if (r2 !== 2'b00) $display("FAIL bp_in_ready: cycle %0d got %b want 00", cyc, r2); else n_pass++;
        n_checks++;
        if ({ov2, os2, of2, ol2} !== 4'b1001 || od2 !== mkdata(0, id0, 1))
          $display("FAIL bp_hold: cycle %0d got v=%b sel=%0d f=%b l=%b data=%h want v=1 sel=0 f=0 l=1 data=%h",
                   cyc, ov2, os2, of2, ol2, od2, mkdata(0, id0, 1));
        else n_pass++;
      end
      cyc++;
      if (ov2 && ordy2) begin
        e = sb.pop_front();
        n_checks++;
        if (os2 !== 1'(e.sel) || od2 !== e.data || of2 !== e.first || ol2 !== e.last)
          $display("FAIL bp_beat: got sel=%0d data=%h f=%b l=%b want sel=%0d data=%h f=%b l=%b",
                   os2, od2, of2, ol2, e.sel, e.data, e.first, e.last);
        else n_pass++;
      end
      adv2();
    end
    ordy2 = 1'b1;
    n_checks++;
    if (sb.size() != 0 || cyc != 5) $display("FAIL bp_cycles: got %0d cycles (%0d left) want 5", cyc, sb.size());
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_gap();
    int id0, id1, cyc;
    exp_t e;
    add_burst(1, 3, id1);
    add_burst(0, 0, id0);
    expect_beats(1, id1, 3, 0, 3);
    expect_beats(0, id0, 0, 0, 0);
    drive2();
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      if (cyc == 1) begin gap[1] = 1'b1; drive2(); end
      if (cyc == 3) begin gap[1] = 1'b0; drive2(); end
      @(negedge clock);
      if (cyc == 1 || cyc == 2) begin
        n_checks++;
        if (ov2 !== 1'b0 || os2 !== 1'b1) $display("FAIL gap_hold: cycle %0d got v=%b sel=%0d want v=0 sel=1", cyc, ov2, os2);
        else n_pass++;
        n_checks++;
        if (r2 !== 2'b10) $display("FAIL gap_in_ready: cycle %0d got %b want 10", cyc, r2); else n_pass++;
      end
      cyc++;
      if (ov2 && ordy2) begin
        e = sb.pop_front();
        n_checks++;
        if (os2 !== 1'(e.sel) || od2 !== e.data || of2 !== e.first || ol2 !== e.last)
          $display("FAIL gap_beat: got sel=%0d data=%h f=%b l=%b want sel=%0d data=%h f=%b l=%b",
                   os2, od2, of2, ol2, e.sel, e.data, e.first, e.last);
        else n_pass++;
      end
      adv2();
    end
    gap[1] = 1'b0;
    n_checks++;
    if (sb.size() != 0 || cyc != 7) $display("FAIL gap_cycles: got %0d cycles (%0d left) want 7", cyc, sb.size());
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_reset_mid();
    int id0, id1, cyc;
    exp_t e;
    add_burst(1, 7, id1);
    expect_beats(1, id1, 7, 0, 1);
    drive2();
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (ov2 && ordy2) begin
        e = sb.pop_front();
        n_checks++;
        if (os2 !== 1'(e.sel) || od2 !== e.data || of2 !== e.first || ol2 !== e.last)
          $display("FAIL rmid_beat: got sel=%0d data=%h f=%b l=%b want sel=%0d data=%h f=%b l=%b",
                   os2, od2, of2, ol2, e.sel, e.data, e.first, e.last);
        else n_pass++;
      end
      adv2();
    end
    reset_n = 1'b0;
    @(negedge clock);
    n_checks++;
    if (r2 !== 2'b00 || ov2 !== 1'b0) $display("FAIL rmid_in_reset: got ready=%b valid=%b want 00/0", r2, ov2);
    else n_pass++;
    bhead[1] = bcnt[1];
    bbeat[1] = 0;
    drive2();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    add_burst(0, 0, id0);
    add_burst(1, 0, id1);
    expect_beats(0, id0, 0, 0, 0);
    expect_beats(1, id1, 0, 0, 0);
    drive2();
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      @(negedge clock);
      cyc++;
      if (ov2 && ordy2) begin
        e = sb.pop_front();
        n_checks++;
        if (os2 !== 1'(e.sel) || od2 !== e.data || of2 !== e.first || ol2 !== e.last)
          $display("FAIL rmid_after: got sel=%0d data=%h f=%b l=%b want sel=%0d data=%h f=%b l=%b",
                   os2, od2, of2, ol2, e.sel, e.data, e.first, e.last);
        else n_pass++;
      end
      adv2();
    end
    n_checks++;
    if (sb.size() != 0 || cyc != 2) $display("FAIL rmid_cycles: got %0d cycles (%0d left) want 2", cyc, sb.size());
    else n_pass++;
    sb.delete();
  endtask

  task automatic test_stress();
    exp_t sq[4][$];
    exp_t e;
    bit act[4];
    bit started[4];
    int len4[4];
    int gid[4];
    int wait_cnt[4];
    int lock, g;
    lock = -1;
    for (int i = 0; i < 4; i++) begin
      act[i] = 1'b0; started[i] = 1'b0; len4[i] = 0; gid[i] = 0; wait_cnt[i] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!act[i] && $urandom_range(0, 3) == 0) begin
          len4[i] = int'($urandom_range(0, 7));
          gid[i]++;
          act[i] = 1'b1;
          started[i] = 1'b0;
          wait_cnt[i] = 0;
          for (int k = 0; k <= len4[i]; k++)
            sq[i].push_back('{i, mkdata(i, gid[i], k), k == 0, k == len4[i]});
        end
        if (act[i]) begin
          v4[i] = started[i] ? ($urandom_range(0, 3) != 0) : 1'b1;
          d4[i*DW +: DW] = sq[i][0].data;
          l4[i*BW +: BW] = BW'(len4[i]);
        end else begin
          v4[i] = 1'b0;
          d4[i*DW +: DW] = $urandom;
          l4[i*BW +: BW] = BW'($urandom_range(0, 7));
        end
      end
      ordy4 = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      n_checks++;
      if ($countones(r4) > 1) $display("FAIL st_onehot: cycle %0d in_ready=%b want at most one bit", cyc, r4);
      else n_pass++;
      n_checks++;
      if (((v4 & r4) != 4'b0) !== (ov4 && ordy4))
        $display("FAIL st_handshake: cycle %0d got valid&ready=%b out_valid&ready=%b want equal", cyc, v4 & r4, ov4 && ordy4);
      else n_pass++;
      if (ov4 && ordy4) begin
        g = -1;
        for (int i = 0; i < 4; i++) if (r4[i]) g = i;
        n_checks++;
        if (g < 0 || !v4[g] || sq[g].size() == 0)
          $display("FAIL st_grant: cycle %0d got in_ready=%b in_valid=%b want a valid granted requester", cyc, r4, v4);
        else begin
          n_pass++;
          e = sq[g].pop_front();
          n_checks++;
          if (os4 !== 2'(g) || od4 !== e.data || of4 !== e.first || ol4 !== e.last)
            $display("FAIL st_beat: cycle %0d got sel=%0d data=%h f=%b l=%b want sel=%0d data=%h f=%b l=%b",
                     cyc, os4, od4, of4, ol4, g, e.data, e.first, e.last);
          else n_pass++;
          if (lock >= 0) begin
            n_checks++;
            if (g != lock) $display("FAIL st_interleave: cycle %0d got beat from %0d want %0d", cyc, g, lock);
            else n_pass++;
          end
          if (e.first) begin
            for (int j = 0; j < 4; j++) begin
              if (j != g && act[j] && !started[j]) begin
                wait_cnt[j]++;
                n_checks++;
                if (wait_cnt[j] > 3) $display("FAIL st_fairness: requester %0d waited %0d bursts want at most 3", j, wait_cnt[j]);
                else n_pass++;
              end
            end
            started[g] = 1'b1;
          end
          if (e.last) begin
            lock = -1;
            act[g] = 1'b0;
          end else begin
            lock = g;
          end
        end
      end
      @(posedge clock);
      #1;
    end
    v4 = '0;
  endtask

  initial begin
    v2 = '0; d2 = '0; l2 = '0; ordy2 = 1'b0;
    v4 = '0; d4 = '0; l4 = '0; ordy4 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bhead[i] = 0; bcnt[i] = 0; bbeat[i] = 0; gap[i] = 1'b0;
    end
    test_reset();
    test_burst_lock();
    test_backpressure();
    test_gap();
    test_reset_mid();
    test_stress();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
